// File: rtl/twitchcore_pkg.sv
// Shared types and constants for the twitchcore memory path.
package twitchcore_pkg;

    localparam int WORD_W = 32;

    // Access sequencer: accept, drive the memory port, return the response
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Which requester owns the access in flight
    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// the previous accepted grant wins; the history only moves when a grant
// is actually accepted.
module rr_arb2
    import twitchcore_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic req_if,
    input  logic req_d,
    input  logic accept,
    output logic gnt_if,
    output logic gnt_d
);

    src_e last_grant;

    // Grant selection: a lone requester wins outright, a tie goes to the other side
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (req_if && req_d) begin
            if (last_grant == SRC_IF) gnt_d  = 1'b1;
            else                      gnt_if = 1'b1;
        end else begin
            gnt_if = req_if;
            gnt_d  = req_d;
        end
    end

    // History register: starts at fetch so the first tie goes to data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= SRC_IF;
        end else if (accept) begin
            // NOTE: non-blocking assignment for all clocked state so every flop samples pre-edge values.
            last_grant <= gnt_d ? SRC_D : SRC_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// load/store. One access in flight at a time: accept, issue, respond.
// Misaligned or out-of-range requests are answered with an error and
// never touch memory.
module mem_arbiter
    import twitchcore_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 16384,
    localparam int IDX_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [WORD_W-1:0] if_rsp_data,
    output logic              if_rsp_err,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_wstrb,
    input  logic [WORD_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [WORD_W-1:0] d_rsp_data,
    output logic              d_rsp_err,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [IDX_W-1:0]  mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_e state;
    logic   live;       // low during reset and for the first cycle after it
    src_e   lat_src;
    logic   lat_we;
    logic   lat_err;

    logic              gnt_if;
    logic              gnt_d;
    logic              accepting;
    logic              handshake;
    logic [ADDR_W-1:0] req_addr;
    logic              req_err;
    logic              good_load;

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req_if (if_req_valid),
        .req_d  (d_req_valid),
        .accept (handshake),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    // Ready only while idle, only to the granted requester; the arbiter
    // never grants both, so at most one ready is high
    always_comb begin
        accepting    = live && (state == IDLE);
        if_req_ready = accepting && gnt_if;
        d_req_ready  = accepting && gnt_d;
        handshake    = if_req_ready || d_req_ready;
        req_addr     = d_req_ready ? d_req_addr : if_req_addr;
        req_err      = (req_addr[1:0] != 2'b00) ||
                       (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS));
    end

    // Sequencer with registered memory-port and response-strobe outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            live         <= 1'b0;
            lat_src      <= SRC_IF;
            lat_we       <= 1'b0;
            lat_err      <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 4'b0000;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_err   <= 1'b0;
            d_rsp_valid  <= 1'b0;
            d_rsp_err    <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        state     <= ISSUE;
                        lat_src   <= d_req_ready ? SRC_D : SRC_IF;
                        lat_we    <= d_req_ready && d_req_we;
                        lat_err   <= req_err;
                        mem_en    <= !req_err;
                        mem_addr  <= req_addr[IDX_W+1:2];
                        mem_we    <= (d_req_ready && d_req_we && !req_err) ? d_req_wstrb : 4'b0000;
                        mem_wdata <= d_req_ready ? d_req_wdata : '0;
                    end
                end
                ISSUE: begin
                    state        <= WAIT;
                    mem_en       <= 1'b0;
                    mem_we       <= 4'b0000;
                    if_rsp_valid <= (lat_src == SRC_IF);
                    if_rsp_err   <= (lat_src == SRC_IF) && lat_err;
                    d_rsp_valid  <= (lat_src == SRC_D);
                    d_rsp_err    <= (lat_src == SRC_D) && lat_err;
                end
                WAIT: begin
                    state        <= IDLE;
                    if_rsp_valid <= 1'b0;
                    if_rsp_err   <= 1'b0;
                    d_rsp_valid  <= 1'b0;
                    d_rsp_err    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response data comes straight from the RAM for a good load, else zero
    always_comb begin
        good_load   = !lat_err && !lat_we;
        if_rsp_data = (if_rsp_valid && good_load) ? mem_rdata : '0;
        d_rsp_data  = (d_rsp_valid  && good_load) ? mem_rdata : '0;
    end

endmodule
